regfile_bank: RTL
=================

// Module: regfile_bank
// PURPOSE
//   Parametrised multi-entry register file for the CPU datapath: one write port, two registered read ports.
//   Adds async reset, write-to-read bypass, a read-valid pipeline and an optional hardwired-zero entry.
//   Sits between decode (read addresses) and writeback (write port). rd_data feeds the ALU operand latches.
// PARAMETERS
//   DATA_W    16  width of each entry and of the data ports
//   ADDR_W    2   address width; DEPTH = 2**ADDR_W entries
//   ZERO_REG  0   1: entry 0 always reads 0 and writes to it are dropped; 0: entry 0 is ordinary
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   wr_en      in   1       write strobe
//   wr_addr    in   ADDR_W  write entry
//   wr_data    in   DATA_W  write data
//   rd_en1     in   1       read request, port 1
//   rd_addr1   in   ADDR_W  read entry, port 1
//   rd_data1   out  DATA_W  registered read data, port 1
//   rd_valid1  out  1       rd_data1 holds the result of the request made the previous cycle
//   rd_en2 / rd_addr2 / rd_data2 / rd_valid2: port 2, identical to port 1
// BEHAVIOUR
//   - Reset (async assert, sync release): all entries, rd_data*, rd_valid* = 0. Reset mid-operation aborts
//     the in-flight read and the pending write. The first edge after release behaves as a normal cycle.
//   - Write: on the posedge with wr_en=1, entry[wr_addr] <= wr_data. When ZERO_REG=1 and wr_addr=0, the write is dropped.
//   - Read latency is 1 cycle. On the posedge with rd_enN=1, rd_dataN <= value(rd_addrN) and rd_validN <= 1.
//     With rd_enN=0, rd_validN <= 0 and rd_dataN holds its last value.
//   - Bypass: if wr_en=1 and wr_addr=rd_addrN on the same edge (and the write is not dropped), rd_dataN
//     takes wr_data, not the stale entry. Both ports may bypass on the same edge.
//   - ZERO_REG=1: a read of entry 0 returns 0 regardless of bypass.
//   - Both ports may read the same address in the same cycle; both return the same value.
//   - Addresses are always in range (DEPTH = 2**ADDR_W), so no out-of-range case exists.
// CONFIGURATION
//   Macro REGFILE_SCOREBOARD_EN:
//   defined -> extra ports:
//     claim_en   in   1       mark an entry pending
//     claim_addr in   ADDR_W  entry to mark
//     rd_busy1   out  1       pending bit for port 1, registered with rd_data1
//     rd_busy2   out  1       pending bit for port 2, registered with rd_data2
//   Scoreboard rules:
//     - busy[DEPTH] resets to 0. claim sets busy[claim_addr]. A non-dropped write clears busy[wr_addr].
//     - claim and write to the same addr on one edge: busy ends set (claim wins).
//     - rd_busyN reflects busy after that edge's write-clear, before its claim-set.
//     - ZERO_REG=1: busy[0] is never set.
//   undefined -> no claim or busy ports, no busy storage; all other behaviour unchanged.
// STRUCTURE
//   - Package regfile_pkg: default DATA_W/ADDR_W localparams, typedef regfile_addr_t, typedef regfile_data_t.
//   - Sub-module regfile_read_port, instantiated twice. Contents: entry mux, bypass compare, ZERO_REG
//     forcing, rd_data/rd_valid (and rd_busy) output registers.
//   - Top level holds the entry array, the write logic and the scoreboard.
// TESTING (DATA_W=16, ADDR_W=2 unless noted)
//   1. Reset 3 cycles, release, read all 4 entries on both ports -> every rd_data=0x0000, rd_valid=1 one cycle
//      after each request, rd_valid=0 whenever rd_en was 0.
//   2. Write e1=0xBEEF, next cycle read e1 on port 1 -> rd_data1=0xBEEF one cycle later.
//   3. Same edge: write e2=0x1234, both ports read e2 -> rd_data1=rd_data2=0x1234 (bypass);
//      re-read next cycle -> 0x1234.
//   4. ZERO_REG=1: write e0=0xFFFF, read e0 same edge and next cycle -> 0x0000 both times.
//   5. Write e3=0xA5A5, assert rst mid-cycle during a read of e3 -> rd_data1=0, rd_valid1=0 immediately;
//      after release, read e3 -> 0x0000.
//   6. SCOREBOARD_EN: claim e1, read e1 -> rd_busy1=1; write e1=0x0042 and claim e1 on the same edge
//      -> busy stays 1; write e1 alone -> next read gives rd_busy1=0, rd_data1=0x0042.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and types for the datapath register file.
// Used by regfile_bank and regfile_read_port (optional feature macro: REGFILE_SCOREBOARD_EN).
package regfile_pkg;

  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_ADDR_W = 2;

  typedef logic [REGFILE_DATA_W-1:0] regfile_data_t;
  typedef logic [REGFILE_ADDR_W-1:0] regfile_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_bank: selects an entry, forwards a
// same-edge write (bypass), forces entry 0 to zero when ZERO_REG=1, and
// registers data/valid (and, with REGFILE_SCOREBOARD_EN, the busy bit).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_en,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [(DATA_W<<ADDR_W)-1:0]    entries_flat,
  input  logic                           wr_live,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic [(1<<ADDR_W)-1:0]         busy_cleared,
  output logic                           rd_busy,
`endif
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] entry_sel [DEPTH];
  logic [DATA_W-1:0] rd_data_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;

  // Unpack the flat entry bus so the mux can index by address.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_unpack
      assign entry_sel[gi] = entries_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Entry mux, then same-edge write forwarding, then hardwired-zero override.
  always_comb begin
    rd_data_next = entry_sel[rd_addr];
    if (wr_live && (wr_addr == rd_addr)) begin
      rd_data_next = wr_data;
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data_next = '0;
    end
  end

  // Output registers: data holds when no request, valid tracks the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_data_reg <= rd_data_next;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

`ifdef REGFILE_SCOREBOARD_EN
  logic rd_busy_reg;

  // Busy bit sampled after this edge's write-clear, alongside rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_busy_reg <= 1'b0;
    end else if (rd_en) begin
      rd_busy_reg <= busy_cleared[rd_addr];
    end
  end

  assign rd_busy = rd_busy_reg;
`endif

endmodule

// File: rtl/regfile_bank.sv
// Datapath register file: one write port, two registered read ports with
// write-to-read bypass and optional hardwired-zero entry 0.
// Optional feature macro REGFILE_SCOREBOARD_EN adds a per-entry pending
// (busy) scoreboard with claim input and rd_busy outputs.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              rd_busy1,
  output logic              rd_busy2,
`endif
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic                      wr_live;
  logic [DEPTH*DATA_W-1:0]   entries_flat;

  // A write to entry 0 is discarded when entry 0 is hardwired to zero.
  assign wr_live = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;

      // Entry storage: cleared by reset, loaded by a live write to this index.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wr_live && (wr_addr == ADDR_W'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entries_flat[gi*DATA_W +: DATA_W] = entry_reg;
    end
  endgenerate

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_cleared;
  logic [DEPTH-1:0] busy_next;
  logic             claim_live;

  assign claim_live = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

  // Write clears first, then claim sets, so a same-edge claim wins.
  always_comb begin
    busy_cleared = busy_reg;
    if (wr_live) begin
      busy_cleared[wr_addr] = 1'b0;
    end
    busy_next = busy_cleared;
    if (claim_live) begin
      busy_next[claim_addr] = 1'b1;
    end
  end

  // Pending-bit storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end
`endif

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port1 (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en1),
    .rd_addr      (rd_addr1),
    .entries_flat (entries_flat),
    .wr_live      (wr_live),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
`ifdef REGFILE_SCOREBOARD_EN
    .busy_cleared (busy_cleared),
    .rd_busy      (rd_busy1),
`endif
    .rd_data      (rd_data1),
    .rd_valid     (rd_valid1)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port2 (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en2),
    .rd_addr      (rd_addr2),
    .entries_flat (entries_flat),
    .wr_live      (wr_live),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
`ifdef REGFILE_SCOREBOARD_EN
    .busy_cleared (busy_cleared),
    .rd_busy      (rd_busy2),
`endif
    .rd_data      (rd_data2),
    .rd_valid     (rd_valid2)
  );

endmodule
